mpu_matrix_streamer: RTL and testbench
======================================

# mpu_matrix_streamer

Transmit side of the MPU matrix path: captures one flattened 5x5 matrix of 8-bit elements (the same 200-bit layout every MPU operation produces) and streams it out one element per beat over a valid/ready handshake, row-major, with row/column tags and a last flag. It sits after an MPU operation block (opposite, add, multiply, ...) and feeds a byte-wide sink such as a result memory or host link.

## Interface
Parameters:
- `DIM`, 5, matrix dimension; the block is specified and verified for 5 only.
- `ELEM_W`, 8, element width in bits.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request to capture `matrix_in` and begin streaming.
- `matrix_in`  in  200  flattened matrix; element (row i, col j) at bits `8*(i+5*j) +: 8`.
- `busy`  out  1  high while a matrix is being streamed.
- `done`  out  1  one-cycle pulse after the final beat is accepted.
- `m_data`  out  8  current element.
- `m_row`  out  3  row index of `m_data`, 0..4.
- `m_col`  out  3  column index of `m_data`, 0..4.
- `m_last`  out  1  high when `m_data` is element (4,4).
- `m_valid`  out  1  beat valid.
- `m_ready`  in  1  sink accepts beat.

## Operation
- States: IDLE, SEND.
- IDLE: `busy`=0, `m_valid`=0. On `start`=1, register `matrix_in` into an internal 200-bit buffer, clear row/col counters to (0,0), go to SEND.
- SEND: `busy`=1, `m_valid`=1. `m_data` is `buffer[8*(row+5*col) +: 8]`, and `m_row`/`m_col` equal the counters. `m_last` = (row==4 && col==4).
- Transfer occurs when `m_valid` && `m_ready`. After a transfer, col increments; at col 4 it wraps to 0 and row increments.
- Transfer with `m_last`=1: go to IDLE, reset the counters to 0, assert `done` for exactly the next cycle.
- Stream order is row-major: (0,0),(0,1)..(0,4),(1,0)..(4,4). That is exactly 25 beats per start.
- `start` while in SEND is ignored. Neither the buffer nor the counters change.
- `matrix_in` changes after capture do not affect the stream.
- While `m_ready`=0, `m_valid`, `m_data`, `m_row`, `m_col` and `m_last` hold stable. `m_valid` never drops before a transfer.
- Elements are passed through bit-exact; there is no arithmetic and no sign handling.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE. `busy`, `done`, `m_valid` and `m_last` are 0. `m_data`, `m_row` and `m_col` are 0. The buffer is cleared.
- Reset mid-stream aborts immediately. Remaining beats are dropped and no `done` is issued.
- Start latency: `start` sampled high at edge t gives `m_valid`=1 with element (0,0) from cycle t+1.
- With `m_ready` held high: beats occur in cycles t+1..t+25, `done`=1 in cycle t+26 and `busy`=0 in cycle t+26.
- Throughput is one element per cycle when `m_ready`=1. Each `m_ready`=0 cycle adds one stall cycle.
- `start` sampled in the `done` cycle is accepted, so back-to-back matrices have a 1-cycle gap.
- `done` and `busy` are never high together.

## Test plan
- Reset values: assert `rst_n`=0 → all outputs are 0. Release, idle 5 cycles → `m_valid` stays 0 and `done` stays 0.
- Ordering: `matrix_in` = concatenation of bytes 1..25 (MSB first), `start` one cycle, `m_ready`=1 → `m_data` sequence 25,20,15,10,5, 24,19,14,9,4, ..., 21,16,11,6,1. `m_row`/`m_col` step (0,0)..(4,4). `m_last` is high only on the value-1 beat. `done` is high at t+26.
- Backpressure: same matrix, `m_ready` toggling 1,0,0,1,... → outputs are stable during low cycles, no beat is lost or duplicated, and 25 transfers complete.
- Ignored start and capture isolation: pulse `start` with a different `matrix_in` at beat 10 → the stream is unchanged and still ends with 1.
- Reset mid-operation: deassert `rst_n` at beat 12 → `m_valid`=0 asynchronously and no `done`. After release, a new `start` streams from (0,0).
- Back-to-back: with all elements 8'hFF, issue `start` in the `done` cycle of the previous matrix → the second stream begins in the next cycle with 25 beats of 255.

Source files
------------

// File: rtl/mpu_matrix_streamer.sv
// mpu_matrix_streamer: captures a flattened DIMxDIM matrix and streams it row-major over valid/ready.
module mpu_matrix_streamer #(
  parameter int DIM    = 5,
  parameter int ELEM_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DIM*DIM*ELEM_W-1:0] matrix_in,
  output logic                      busy,
  output logic                      done,
  output logic [ELEM_W-1:0]         m_data,
  output logic [2:0]                m_row,
  output logic [2:0]                m_col,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready
);
  localparam int MW = DIM*DIM*ELEM_W;
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_nx;
  logic [MW-1:0] buffer, shifted;
  logic [2:0] row, col;
  logic fire, row_wrap, col_wrap;
  int idx;
  assign fire     = m_valid && m_ready;
  assign row_wrap = row == 3'(DIM-1);
  assign col_wrap = col == 3'(DIM-1);
  // column-major storage, row-major traversal
  assign idx      = int'(row) + DIM*int'(col);
  assign shifted  = buffer >> (ELEM_W*idx);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (start ? SEND : IDLE) : (fire && m_last ? IDLE : SEND);
  always_comb begin
    busy    = state == SEND;
    m_valid = busy;
    m_last  = busy && row_wrap && col_wrap;
    m_data  = busy ? shifted[ELEM_W-1:0] : '0;
    m_row   = row;
    m_col   = col;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      buffer <= '0;
      row    <= '0;
      col    <= '0;
      done   <= 1'b0;
    end else begin
      done <= fire && m_last;
      if (state == IDLE && start) begin
        buffer <= matrix_in;
        row    <= '0;
        col    <= '0;
      end else if (fire) begin
        col <= col_wrap ? '0 : col + 3'd1;
        row <= col_wrap ? (row_wrap ? '0 : row + 3'd1) : row;
      end
    end
endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// tb_mpu_matrix_streamer: directed stimulus with a beat scoreboard and handshake-hold monitor.
module tb_mpu_matrix_streamer;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 0;
  logic [199:0] matrix_in = '0, ord_m, ff_m, alt_m;
  logic busy, done, m_last, m_valid;
  logic [7:0] m_data;
  logic [2:0] m_row, m_col;
  logic [14:0] sb[$];
  logic [15:0] snap;
  logic prev_stall = 0;
  int checks = 0, errors = 0, beats = 0;

  mpu_matrix_streamer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_in(matrix_in),
    .busy(busy), .done(done), .m_data(m_data), .m_row(m_row), .m_col(m_col),
    .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_matrix(input logic [199:0] m);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        sb.push_back({m[8*(r+5*c) +: 8], 3'(r), 3'(c), r == 4 && c == 4});
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && done !== 1'b1; i++) step();
    chk("done_seen", 32'(done), 1);
  endtask

  always @(negedge clk) begin
    logic [14:0] exp;
    if (rst_n) begin
      chk("done_busy_excl", 32'(done & busy), 0);
      if (prev_stall) chk("hold_stable", 32'({m_valid, m_data, m_row, m_col, m_last}), 32'(snap));
      if (m_valid && m_ready) begin
        beats++;
        if (sb.size() == 0) chk("unexpected_beat", 1, 0);
        else begin
          exp = sb.pop_front();
          chk("beat", 32'({m_data, m_row, m_col, m_last}), 32'(exp));
        end
      end
      prev_stall = m_valid && !m_ready;
      snap = {m_valid, m_data, m_row, m_col, m_last};
    end else prev_stall = 0;
  end

  initial begin
    for (int k = 1; k <= 25; k++) ord_m[8*(25-k) +: 8] = 8'(k);
    ff_m = {200{1'b1}};
    for (int k = 0; k < 25; k++) alt_m[8*k +: 8] = 8'(8'hA0 + k);
    #1;
    chk("rst_outputs", 32'({busy, done, m_data, m_row, m_col, m_last, m_valid}), 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid_done", 32'({m_valid, done}), 0);
    end

    // ordering with ready held high
    matrix_in = ord_m;
    m_ready = 1;
    push_matrix(ord_m);
    start = 1;
    step();
    start = 0;
    matrix_in = '0;
    chk("first_data", 32'(m_data), 25);
    for (int i = 0; i < 25; i++) begin
      chk("valid_during_stream", 32'({m_valid, busy, done}), 32'b110);
      if (i == 24) chk("last_data", 32'({m_data, m_last}), {8'd1, 1'b1});
      step();
    end
    chk("done_t26", 32'({done, busy, m_valid}), 32'b100);
    step();
    chk("done_one_cycle", 32'(done), 0);
    chk("ordering_beats", beats, 25);

    // backpressure 1,0,0 repeating
    beats = 0;
    matrix_in = ord_m;
    push_matrix(ord_m);
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 200 && done !== 1'b1; i++) begin
      m_ready = (i % 3) == 0;
      step();
    end
    chk("bp_done", 32'(done), 1);
    chk("bp_beats", beats, 25);
    chk("bp_sb_empty", sb.size(), 0);

    // start during SEND ignored, later matrix_in changes isolated
    m_ready = 1;
    beats = 0;
    matrix_in = ord_m;
    push_matrix(ord_m);
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 10; i++) step();
    matrix_in = alt_m;
    start = 1;
    step();
    start = 0;
    wait_done(40);
    chk("ign_beats", beats, 25);
    chk("ign_sb_empty", sb.size(), 0);
    step();
    chk("ign_no_restart", 32'({m_valid, busy}), 0);

    // reset mid-stream
    matrix_in = ord_m;
    push_matrix(ord_m);
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 12; i++) step();
    rst_n = 0;
    #1;
    chk("rst_mid_async", 32'({m_valid, busy, done, m_data}), 0);
    sb.delete();
    step();
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_mid_no_done", 32'({done, m_valid}), 0);
    end
    beats = 0;
    matrix_in = alt_m;
    push_matrix(alt_m);
    start = 1;
    step();
    start = 0;
    chk("restart_origin", 32'({m_row, m_col, m_data}), {3'd0, 3'd0, 8'hA0});
    wait_done(40);
    chk("restart_beats", beats, 25);

    // back-to-back all 0xFF
    step();
    beats = 0;
    matrix_in = ff_m;
    push_matrix(ff_m);
    start = 1;
    step();
    start = 0;
    wait_done(40);
    push_matrix(ff_m);
    start = 1;
    step();
    start = 0;
    chk("b2b_second_start", 32'({m_valid, m_row, m_col, m_data}), {1'b1, 3'd0, 3'd0, 8'hFF});
    wait_done(40);
    chk("b2b_beats", beats, 50);
    chk("b2b_sb_empty", sb.size(), 0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
